seg7_scan_decoder: RTL
======================

# seg7_scan_decoder

Receiving end of the multiplexed seven-segment display interface: monitors a scanned 4-digit anode/segment bus and reconstructs the hex value shown on each digit. It sits on the observation side of the display driver, for self-check and loopback of the display path, and can also snoop an external board's display lines. Inputs are synchronised and must hold a stable pattern for a programmable dwell before a digit is accepted.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical synchronised samples required to accept a digit; legal range 2–255.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `an_n`  in  4  digit anodes, active-low; bit i selects digit i.
- `seg_n`  in  7  segments, active-low; bit 6 = a, bit 5 = b, … bit 0 = g.
- `digits`  out  16  decoded values; digit i at `[4i+3:4i]`.
- `valid`  out  4  per-digit flag; 1 = `digits` holds a decoded value for that digit.
- `upd`  out  1  one-cycle pulse when a digit is accepted.
- `upd_idx`  out  2  index of the digit accepted with `upd`.
- `err`  out  1  unrecognised segment pattern (see Configuration).
- `err_idx`  out  2  digit index associated with `err`.

## Operation
- **Input synchroniser.**
  - 2-flop synchroniser `s1` → `s2` on `{an_n, seg_n}`.
  - `s2` is the sample stream; all further logic sees only `s2`.
- **Active digit.**
  - A sample is active when exactly one `an_n` bit is 0.
  - Zero or more than one low bit makes the sample inactive.
- **Dwell counter (`run`).**
  - Saturates at `STABLE_CYCLES`.
  - Active sample equal to the previous sample (anode and segments): `run` = min(`run` + 1, `STABLE_CYCLES`).
  - Active sample that differs: `run` = 1.
  - Inactive sample: `run` = 0.
- **Acceptance.**
  - Fires once per dwell, only on the sample where `run` reaches `STABLE_CYCLES`.
  - A continuing dwell never re-fires.
- **Decode** on acceptance, with `p` = ~`seg_n`:
  - Table: 0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:70 8:7F 9:7B A:77 B:1F C:4E D:3D E:4F F:47.
  - Table match: `digits[idx]` ← value, `valid[idx]` ← 1, `upd` = 1, `upd_idx` ← idx.
  - `p` = 00 (blank): `valid[idx]` ← 0, `digits[idx]` unchanged, no `upd`, no `err`.
  - Any other `p`: `err` event, `err_idx` ← idx; `digits` and `valid` unchanged.
- Other digits are never affected by an acceptance.

## Timing
- **Reset values:**
  - `s1`/`s2` = all ones (inactive, blank).
  - `run` = 0, `digits` = 0, `valid` = 0.
  - `upd` = 0, `upd_idx` = 0, `err` = 0, `err_idx` = 0.
- **Latency.** Inputs are stable from edge 1, the first edge that samples them. `digits`, `valid`, `upd` and `err` change at edge `STABLE_CYCLES` + 2.
- `upd` is high for exactly one cycle per accepted dwell.
- **Dwell shortfall.** A dwell of `STABLE_CYCLES` − 1 samples, followed by a change or an inactive sample, produces no update.
- **Anode change with unchanged segments** counts as a new dwell, with `run` = 1.
- **Reset mid-dwell.** Clears the synchroniser and `run`. A full dwell is needed afterwards; outputs are held at reset values meanwhile.
- **`rst` has priority** over any acceptance in the same cycle.

## Configuration
- **Macro:** `SEG7_ERR_STICKY_EN`.
- **Defined:**
  - `err` sets on the first bad-pattern event and stays 1 until `rst`.
  - `err_idx` holds the index of that first failure; later errors do not update it.
- **Undefined:**
  - `err` is a one-cycle pulse per bad-pattern acceptance.
  - `err_idx` updates with each pulse.

## Test plan
- **Single digit.** `STABLE_CYCLES`=4; hold `an_n`=1110, `seg_n`=~7'h79 for 10 cycles → one `upd` at edge 6, `upd_idx`=0, `digits`=0x0003, `valid`=0001.
- **Full scan.** Cycle digits 0–3 showing 8, A, 5, F, dwell 6 each → `digits`=0xF5A8, `valid`=1111, four `upd` pulses, no repeats.
- **Short dwell / multiple anodes.**
  - 3-cycle dwell: no `upd`.
  - `an_n`=1100 for 10 cycles: no `upd`, no `err`, `run` stays 0.
- **Bad pattern.** Digit 2 with `seg_n`=~7'h01:
  - Without the macro: one-cycle `err`, `err_idx`=2, `digits` unchanged.
  - With the macro: `err` stays high through later good digits until `rst`.
- **Blank.** After digit 1 is accepted as 7, blank digit 1 (`seg_n`=7'h7F) for 4 cycles → `valid[1]`=0, `digits[7:4]` remains 7, no `upd`.
- **Reset mid-dwell.** Assert `rst` at dwell sample 3 → all outputs 0. Continuing the same input yields `upd` at edge `STABLE_CYCLES` + 2 counted from the first edge after reset deasserts.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
//
// Observes a scanned 4-digit seven-segment bus (active-low anodes and
// segments) and rebuilds the hex value shown on each digit. A digit is
// accepted only after its anode/segment pattern has been stable for
// STABLE_CYCLES consecutive synchronised samples.
//
// Parameters
//   STABLE_CYCLES  identical samples required to accept a digit (2..255)
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   an_n     in   [3:0] digit anodes, active-low, bit i = digit i
//   seg_n    in   [6:0] segments, active-low, bit 6 = a ... bit 0 = g
//   digits   out  [15:0] decoded values, digit i at [4i+3:4i]
//   valid    out  [3:0] per-digit "holds a decoded value" flag
//   upd      out  one-cycle pulse when a digit is accepted
//   upd_idx  out  [1:0] index of the digit accepted with upd
//   err      out  unrecognised segment pattern seen
//   err_idx  out  [1:0] digit index associated with err
//
// Build option
//   SEG7_ERR_STICKY_EN  defined:   err latches on the first bad pattern until
//                                  rst, err_idx keeps that first index.
//                       undefined: err pulses once per bad acceptance and
//                                  err_idx follows every pulse.
// -----------------------------------------------------------------------------
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an_n,
  input  logic [6:0]  seg_n,
  output logic [15:0] digits,
  output logic [3:0]  valid,
  output logic        upd,
  output logic [1:0]  upd_idx,
  output logic        err,
  output logic [1:0]  err_idx
);

  localparam logic [7:0] LP_STABLE = 8'(STABLE_CYCLES);

  // {an_n, seg_n} as one sample word; all ones = no anode, blank segments.
  localparam logic [10:0] LP_IDLE = '1;

  logic [10:0] r_s1;
  logic [10:0] r_s2;
  logic [10:0] r_prev;
  logic [7:0]  r_run;
  logic [15:0] r_digits;
  logic [3:0]  r_valid;
  logic        r_upd;
  logic [1:0]  r_upd_idx;
  logic        r_err;
  logic [1:0]  r_err_idx;

  logic        w_active;
  logic [1:0]  w_idx;
  logic        w_same;
  logic [7:0]  w_run_next;
  logic        w_accept;
  logic [6:0]  w_pat;
  logic        w_hit;
  logic [3:0]  w_val;

  // Segment pattern (a..g, active-high) to hex value; hit=0 when unknown.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h7E: decode = {1'b1, 4'h0};
      7'h30: decode = {1'b1, 4'h1};
      7'h6D: decode = {1'b1, 4'h2};
      7'h79: decode = {1'b1, 4'h3};
      7'h33: decode = {1'b1, 4'h4};
      7'h5B: decode = {1'b1, 4'h5};
      7'h5F: decode = {1'b1, 4'h6};
      7'h70: decode = {1'b1, 4'h7};
      7'h7F: decode = {1'b1, 4'h8};
      7'h7B: decode = {1'b1, 4'h9};
      7'h77: decode = {1'b1, 4'hA};
      7'h1F: decode = {1'b1, 4'hB};
      7'h4E: decode = {1'b1, 4'hC};
      7'h3D: decode = {1'b1, 4'hD};
      7'h4F: decode = {1'b1, 4'hE};
      7'h47: decode = {1'b1, 4'hF};
      default: decode = 5'b0_0000;
    endcase
  endfunction

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_active = 1'b1;
    w_idx    = 2'd0;
    // Exactly one low anode bit makes the sample active.
    case (r_s2[10:7])
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_active = 1'b0;
    endcase

    // A changed anode with the same segments is a different sample.
    w_same = (r_s2 == r_prev);

    if (!w_active) begin
      w_run_next = 8'd0;
    end else if (w_same) begin
      w_run_next = (r_run == LP_STABLE) ? r_run : r_run + 8'd1;
    end else begin
      w_run_next = 8'd1;
    end

    // Fires only on the transition into saturation, never while it persists.
    w_accept = (w_run_next == LP_STABLE) && (r_run != LP_STABLE);

    w_pat            = ~r_s2[6:0];
    {w_hit, w_val}   = decode(w_pat);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the synchroniser resets to all ones (no anode, blank) rather
      // than zero, since zero would look like all four anodes driven.
      r_s1      <= LP_IDLE;
      r_s2      <= LP_IDLE;
      r_prev    <= LP_IDLE;
      r_run     <= 8'd0;
      r_digits  <= 16'h0000;
      r_valid   <= 4'b0000;
      r_upd     <= 1'b0;
      r_upd_idx <= 2'd0;
      r_err     <= 1'b0;
      r_err_idx <= 2'd0;
    end else begin
      r_s1   <= {an_n, seg_n};
      r_s2   <= r_s1;
      r_prev <= r_s2;
      r_run  <= w_run_next;

      r_upd <= 1'b0;
`ifndef SEG7_ERR_STICKY_EN
      r_err <= 1'b0;
`endif

      if (w_accept) begin
        if (w_hit) begin
          r_digits[4*w_idx +: 4] <= w_val;
          r_valid[w_idx]         <= 1'b1;
          r_upd                  <= 1'b1;
          r_upd_idx              <= w_idx;
        end else if (w_pat == 7'h00) begin
          // Blank digit: the value is kept, only its validity is withdrawn.
          r_valid[w_idx] <= 1'b0;
        end else begin
`ifdef SEG7_ERR_STICKY_EN
          if (!r_err) begin
            r_err     <= 1'b1;
            r_err_idx <= w_idx;
          end
`else
          r_err     <= 1'b1;
          r_err_idx <= w_idx;
`endif
        end
      end
    end
  end

  assign digits  = r_digits;
  assign valid   = r_valid;
  assign upd     = r_upd;
  assign upd_idx = r_upd_idx;
  assign err     = r_err;
  assign err_idx = r_err_idx;

endmodule
